// File: rtl/ctr_wt_chk.sv
// Sequence checker for the wrap-at-limit counter: predicts the next count from the
// previous sample, locks onto a valid stream, then counts deviations and completed wraps.
module ctr_wt_chk #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned MAX_MISS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] a,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] wrap_cnt
);

  localparam int unsigned MR_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MS_W = $clog2(MAX_MISS + 1);

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e           state_q, state_d;
  logic             hist_v_q, hist_v_d;
  logic [WIDTH-1:0] prev_a_q, prev_a_d;
  logic [WIDTH-1:0] prev_n_q, prev_n_d;
  logic             prev_en_q, prev_en_d;
  logic [MR_W-1:0]  match_run_q, match_run_d;
  logic [MS_W-1:0]  miss_run_q, miss_run_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic [WIDTH-1:0] exp_a;
  logic             at_limit;
  logic             wrap_ev;
  logic             match;
  logic [MR_W-1:0]  match_inc;
  logic [MS_W-1:0]  miss_inc;

  // Reference counter: a limit of 0 or a count already past the limit both predict 0.
  always_comb begin
    at_limit = (prev_a_q >= prev_n_q);
    if (!prev_en_q)    exp_a = prev_a_q;
    else if (at_limit) exp_a = '0;
    else               exp_a = prev_a_q + 1'b1;
    wrap_ev   = prev_en_q & at_limit;
    match     = (a == exp_a);
    match_inc = match_run_q + 1'b1;
    miss_inc  = miss_run_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    hist_v_d    = 1'b1;
    prev_a_d    = a;
    prev_n_d    = n;
    prev_en_d   = en;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    wrap_cnt_d  = wrap_cnt_q;

    if (hist_v_q) begin
      unique case (state_q)
        UNLOCKED: begin
          match_run_d = match ? match_inc : '0;
          if (match && (match_inc == MR_W'(LOCK_CNT))) begin
            state_d     = LOCKED;
            match_run_d = '0;
            miss_run_d  = '0;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_run_d = '0;
            if (wrap_ev && (wrap_cnt_q != '1)) wrap_cnt_d = wrap_cnt_q + 1'b1;
          end else begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            miss_run_d = miss_inc;
            if (miss_inc == MS_W'(MAX_MISS)) begin
              state_d     = UNLOCKED;
              match_run_d = '0;
              miss_run_d  = '0;
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      hist_v_q    <= 1'b0;
      prev_a_q    <= '0;
      prev_n_q    <= '0;
      prev_en_q   <= 1'b0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      wrap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      hist_v_q    <= hist_v_d;
      prev_a_q    <= prev_a_d;
      prev_n_q    <= prev_n_d;
      prev_en_q   <= prev_en_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
      wrap_cnt_q  <= wrap_cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
  assign wrap_cnt  = wrap_cnt_q;

endmodule

// File: tb/tb_ctr_wt_chk.sv
// Randomized and directed bench for ctr_wt_chk against a behavioural stream model.
module tb_ctr_wt_chk;

  localparam int WIDTH    = 4;
  localparam int ERR_W    = 8;
  localparam int LOCK_CNT = 3;
  localparam int MAX_MISS = 2;
  localparam int AMASK    = (1 << WIDTH) - 1;
  localparam int CMAX     = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [WIDTH-1:0] n = '0;
  logic [WIDTH-1:0] a = '0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W-1:0] wrap_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_have_prev, m_pa, m_pn, m_pen;
  int m_locked, m_pulse, m_err, m_wrap, m_good_run, m_bad_run;

  ctr_wt_chk #(.WIDTH(WIDTH), .ERR_W(ERR_W), .LOCK_CNT(LOCK_CNT), .MAX_MISS(MAX_MISS)) dut (
    .clk(clk), .rst(rst), .en(en), .n(n), .a(a),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int r, input int e, input int nn, input int aa);
    int predicted;
    bit hit, wrapped;
    if (r != 0) begin
      m_have_prev = 0; m_locked = 0; m_pulse = 0; m_err = 0; m_wrap = 0;
      m_good_run = 0; m_bad_run = 0;
      return;
    end
    m_pulse = 0;
    if (m_have_prev != 0) begin
      if (m_pen == 0)       predicted = m_pa;
      else if (m_pa >= m_pn) predicted = 0;
      else                  predicted = (m_pa + 1) & AMASK;
      wrapped = (m_pen != 0) && (m_pa >= m_pn);
      hit = (aa == predicted);
      if (m_locked == 0) begin
        m_good_run = hit ? m_good_run + 1 : 0;
        if (m_good_run == LOCK_CNT) begin
          m_locked = 1; m_good_run = 0; m_bad_run = 0;
        end
      end else if (hit) begin
        m_bad_run = 0;
        if (wrapped && m_wrap < CMAX) m_wrap++;
      end else begin
        m_pulse = 1;
        if (m_err < CMAX) m_err++;
        m_bad_run++;
        if (m_bad_run == MAX_MISS) begin
          m_locked = 0; m_good_run = 0; m_bad_run = 0;
        end
      end
    end
    m_pa = aa; m_pn = nn; m_pen = e; m_have_prev = 1;
  endtask

  // Single compare point: drive away from the edge, sample 1 time unit after it.
  task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] nn,
                      input logic [WIDTH-1:0] aa);
    @(negedge clk);
    rst = r; en = e; n = nn; a = aa;
    @(posedge clk);
    #1;
    model_edge(int'(r), int'(e), int'(nn), int'(aa));
    chk("locked",    int'(locked),    m_locked);
    chk("err_pulse", int'(err_pulse), m_pulse);
    chk("err_cnt",   int'(err_cnt),   m_err);
    chk("wrap_cnt",  int'(wrap_cnt),  m_wrap);
  endtask

  function automatic logic [WIDTH-1:0] next_a(input logic pe, input logic [WIDTH-1:0] pa,
                                              input logic [WIDTH-1:0] pn);
    if (!pe)      return pa;
    if (pa >= pn) return '0;
    return pa + 1'b1;
  endfunction

  initial begin
    logic [WIDTH-1:0] ga, gn, va;
    logic             ge, vr, ve;

    // 1: reset, then a full 0..15 count on n=15
    step(1'b1, 1'b0, 4'd0, 4'd0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err_cnt), 0);
    chk("rst_wrap", int'(wrap_cnt), 0);
    for (int i = 0; i < 18; i++) begin
      step(1'b0, 1'b1, 4'd15, 4'(i % 16));
      if (i == 2) chk("t1_not_yet_locked", int'(locked), 0);
      if (i == 3) chk("t1_locked_4th", int'(locked), 1);
    end
    chk("t1_wrap", int'(wrap_cnt), 1);
    chk("t1_err", int'(err_cnt), 0);

    // 2: n=5 stream, one bad sample, then the stream continues at 0
    step(1'b1, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 4'd5, 4'(i % 6));
    step(1'b0, 1'b1, 4'd5, 4'd3);
    chk("t2_pulse", int'(err_pulse), 1);
    chk("t2_err1", int'(err_cnt), 1);
    chk("t2_still_locked", int'(locked), 1);
    step(1'b0, 1'b1, 4'd5, 4'd0);
    chk("t2_err2", int'(err_cnt), 2);
    chk("t2_unlocked", int'(locked), 0);
    step(1'b0, 1'b1, 4'd5, 4'd1);
    chk("t2_pulse_clear", int'(err_pulse), 0);

    // 3: held enable, then a jump while held
    step(1'b1, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'd15, 4'(i));
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd15, 4'd7);
    chk("t3_hold_err", int'(err_cnt), 0);
    chk("t3_hold_wrap", int'(wrap_cnt), 0);
    step(1'b0, 1'b0, 4'd15, 4'd9);
    chk("t3_jump_pulse", int'(err_pulse), 1);
    chk("t3_jump_err", int'(err_cnt), 1);

    // 4: n=0 (every edge a wrap), then n changes to 3 mid-run
    step(1'b1, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'd0, 4'd0);
    chk("t4_locked", int'(locked), 1);
    chk("t4_wrap3", int'(wrap_cnt), 3);
    step(1'b0, 1'b1, 4'd3, 4'd0);
    chk("t4_old_limit", int'(wrap_cnt), 4);
    step(1'b0, 1'b1, 4'd3, 4'd1);
    step(1'b0, 1'b1, 4'd3, 4'd2);
    step(1'b0, 1'b1, 4'd3, 4'd3);
    step(1'b0, 1'b1, 4'd3, 4'd0);
    chk("t4_err", int'(err_cnt), 0);
    chk("t4_wrap5", int'(wrap_cnt), 5);

    // 5: out-of-range start
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 4'd9, 4'd12);
    step(1'b0, 1'b1, 4'd9, 4'd0);
    step(1'b0, 1'b1, 4'd9, 4'd1);
    step(1'b0, 1'b1, 4'd9, 4'd2);
    chk("t5_locked", int'(locked), 1);
    step(1'b0, 1'b1, 4'd9, 4'd3);
    chk("t5_err", int'(err_cnt), 0);

    // Randomized streams: mostly legal counting, occasional glitches, limit changes, resets
    ga = '0; ge = 1'b0; gn = 4'd15;
    step(1'b1, 1'b0, gn, ga);
    for (int i = 0; i < 3000; i++) begin
      ve = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) gn = 4'($urandom);
      va = next_a(ge, ga, gn);
      if ($urandom_range(0, 15) == 0) va = 4'($urandom);
      vr = ($urandom_range(0, 299) == 0);
      step(vr, ve, gn, va);
      ga = va; ge = ve;
    end

    // 6: saturate err_cnt with isolated glitches on a held stream
    step(1'b1, 1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'd15, 4'(i));
    step(1'b0, 1'b0, 4'd15, 4'd7);
    chk("t6_locked", int'(locked), 1);
    for (int k = 0; k < 256; k++) begin
      va = (k % 2 == 0) ? 4'd8 : 4'd7;
      step(1'b0, 1'b0, 4'd15, va);
      step(1'b0, 1'b0, 4'd15, va);
    end
    chk("t6_sat", int'(err_cnt), 255);
    chk("t6_locked_sat", int'(locked), 1);
    step(1'b0, 1'b0, 4'd15, 4'd8);
    chk("t6_sat_more", int'(err_cnt), 255);
    step(1'b1, 1'b0, 4'd15, 4'd8);
    chk("t6_rst_err", int'(err_cnt), 0);
    chk("t6_rst_locked", int'(locked), 0);
    chk("t6_rst_pulse", int'(err_pulse), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 4'd15, 4'(i));
      if (i < 3) chk("t6_relock_wait", int'(locked), 0);
    end
    chk("t6_relocked", int'(locked), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
